ps2_cmd_ctrl: RTL and testbench

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_cmd_ctrl_if.sv | 24 ++
 rtl/ps2_sync_edge.sv | 31 +++
 rtl/ps2_cmd_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared FSM encoding, failure codes and device response bytes for the
// PS/2 host command controller.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_START   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RESP    = 3'd5
    } ps2_state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_NO_ACK  = 2'd1;
    localparam logic [1:0] ERR_RESEND  = 2'd2;
    localparam logic [1:0] ERR_UNEXP   = 2'd3;

    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;

    localparam logic [1:0] MAX_RETRY   = 2'd2;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_cmd_ctrl_if.sv
// Command / receive-path handshake bundle between a host and ps2_cmd_ctrl.
interface ps2_cmd_ctrl_if;

    logic       i_cmd_valid;
    logic [7:0] i_cmd_data;
    logic       o_cmd_ready;
    logic       i_rx_valid;
    logic [7:0] i_rx_byte;
    logic       o_rx_inhibit;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_err_code;

    modport slave (
        input  i_cmd_valid, i_cmd_data, i_rx_valid, i_rx_byte,
        output o_cmd_ready, o_rx_inhibit, o_done, o_err, o_err_code
    );

    modport master (
        output i_cmd_valid, i_cmd_data, i_rx_valid, i_rx_byte,
        input  o_cmd_ready, o_rx_inhibit, o_done, o_err, o_err_code
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an idle-high PS/2 line with a one-cycle
// falling-edge strobe (synchronized 1 followed by synchronized 0).
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one delayed copy; preset high to match an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_out = sync_r;
    assign fall     = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-device command sender: inhibit, framed transmit, line ACK,
// device response handling with resend retries and a per-state watchdog.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic           CLK_50M,
    input  logic           RST,
    input  logic           PS2_CLK,
    input  logic           PS2_DATA,
    output logic           o_clk_oe,
    output logic           o_data_oe,
    ps2_cmd_ctrl_if.slave  bus
);

    if (CLK_HZ <= 0 || INHIBIT_CYC < 1 || INHIBIT_CYC > 1048576 ||
        TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1048576) begin : g_param_check
        $error("ps2_cmd_ctrl: parameter out of range");
    end

    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYC - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYC - 1);

    ps2_state_t  state_r, state_s;
    logic [19:0] cnt_r, cnt_s;
    logic [3:0]  edge_r, edge_s;
    logic [1:0]  retry_r, retry_s;
    logic [7:0]  byte_r, byte_s;
    logic        parity_r, parity_s;
    logic        ack_r, ack_s;
    logic [10:0] frame_s;

    logic        ready_r, ready_s;
    logic        clk_oe_r, clk_oe_s;
    logic        data_oe_r, data_oe_s;
    logic        rx_inh_r, rx_inh_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [1:0]  code_r, code_s;

    logic        clk_level_s, clk_fall_s;
    logic        data_sync_s, data_fall_s;
    logic        unused_s;

    ps2_sync_edge u_sync_clk (
        .clk      (CLK_50M),
        .rst      (RST),
        .async_in (PS2_CLK),
        .sync_out (clk_level_s),
        .fall     (clk_fall_s)
    );

    ps2_sync_edge u_sync_data (
        .clk      (CLK_50M),
        .rst      (RST),
        .async_in (PS2_DATA),
        .sync_out (data_sync_s),
        .fall     (data_fall_s)
    );

    assign unused_s = clk_level_s ^ data_fall_s;

    // Next-state, counters and next registered outputs (derived from the next state).
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r + 20'd1;
        edge_s   = edge_r;
        retry_s  = retry_r;
        byte_s   = byte_r;
        parity_s = parity_r;
        ack_s    = ack_r;
        done_s   = 1'b0;
        err_s    = 1'b0;
        code_s   = code_r;

        case (state_r)
            ST_IDLE: begin
                cnt_s  = 20'd0;
                edge_s = 4'd0;
                if (bus.i_cmd_valid && ready_r) begin
                    byte_s   = bus.i_cmd_data;
                    parity_s = odd_parity(bus.i_cmd_data);
                    retry_s  = 2'd0;
                    code_s   = ERR_TIMEOUT;
                    state_s  = ST_INHIBIT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (cnt_r == INH_LAST) begin
                    cnt_s   = 20'd0;
                    state_s = ST_START;
                end else begin
                    state_s = ST_INHIBIT;
                end
            end
            ST_START: begin
                cnt_s   = 20'd0;
                edge_s  = 4'd0;
                state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (clk_fall_s) begin
                    cnt_s  = 20'd0;
                    edge_s = edge_r + 4'd1;
                    if (edge_r == 4'd10) begin
                        ack_s   = data_sync_s;
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else if (cnt_r == TO_LAST) begin
                    cnt_s   = 20'd0;
                    err_s   = 1'b1;
                    code_s  = ERR_TIMEOUT;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_ACK: begin
                cnt_s = 20'd0;
                if (!ack_r) begin
                    state_s = ST_RESP;
                end else begin
                    err_s   = 1'b1;
                    code_s  = ERR_NO_ACK;
                    state_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (bus.i_rx_valid) begin
                    cnt_s = 20'd0;
                    if (bus.i_rx_byte == RESP_ACK) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else if (bus.i_rx_byte == RESP_RESEND && retry_r < MAX_RETRY) begin
                        retry_s = retry_r + 2'd1;
                        state_s = ST_INHIBIT;
                    end else if (bus.i_rx_byte == RESP_RESEND) begin
                        err_s   = 1'b1;
                        code_s  = ERR_RESEND;
                        state_s = ST_IDLE;
                    end else begin
                        err_s   = 1'b1;
                        code_s  = ERR_UNEXP;
                        state_s = ST_IDLE;
                    end
                end else if (cnt_r == TO_LAST) begin
                    cnt_s   = 20'd0;
                    err_s   = 1'b1;
                    code_s  = ERR_TIMEOUT;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                cnt_s   = 20'd0;
                state_s = ST_IDLE;
            end
        endcase

        // Frame as seen on the wire: start(0), d0..d7, parity, stop(1).
        frame_s   = {1'b1, parity_s, byte_s, 1'b0};
        ready_s   = (state_s == ST_IDLE);
        clk_oe_s  = (state_s == ST_INHIBIT);
        rx_inh_s  = (state_s == ST_INHIBIT) || (state_s == ST_START) ||
                    (state_s == ST_SHIFT)   || (state_s == ST_ACK);
        data_oe_s = 1'b0;
        case (state_s)
            ST_INHIBIT: data_oe_s = (cnt_s == INH_LAST);
            ST_START:   data_oe_s = 1'b1;
            ST_SHIFT: begin
                if (edge_s <= 4'd10) begin
                    data_oe_s = ~frame_s[edge_s];
                end else begin
                    data_oe_s = 1'b0;
                end
            end
            default:    data_oe_s = 1'b0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 20'd0;
            edge_r    <= 4'd0;
            retry_r   <= 2'd0;
            byte_r    <= 8'd0;
            parity_r  <= 1'b0;
            ack_r     <= 1'b0;
            ready_r   <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            rx_inh_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            code_r    <= 2'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            edge_r    <= edge_s;
            retry_r   <= retry_s;
            byte_r    <= byte_s;
            parity_r  <= parity_s;
            ack_r     <= ack_s;
            ready_r   <= ready_s;
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            rx_inh_r  <= rx_inh_s;
            done_r    <= done_s;
            err_r     <= err_s;
            code_r    <= code_s;
        end
    end

    assign o_clk_oe         = clk_oe_r;
    assign o_data_oe        = data_oe_r;
    assign bus.o_cmd_ready  = ready_r;
    assign bus.o_rx_inhibit = rx_inh_r;
    assign bus.o_done       = done_r;
    assign bus.o_err        = err_r;
    assign bus.o_err_code   = code_r;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Scoreboard bench for ps2_cmd_ctrl with a behavioural PS/2 device model
// (open-drain lines, device-generated clock) and scaled-down timing parameters.
module tb_ps2_cmd_ctrl;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TO  = 3000;
    localparam int H   = 12;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
    } exp_t;

    logic clk          = 1'b0;
    logic rst          = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_oe;
    logic data_oe;
    logic ps2_clk;
    logic ps2_data;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   inh_run   = 0;
    int   inh_first = 0;
    int   inh_seen  = 0;
    exp_t sb[$];

    ps2_cmd_ctrl_if bus ();

    assign ps2_clk  = ~(clk_oe  | dev_clk_low);
    assign ps2_data = ~(data_oe | dev_data_low);

    ps2_cmd_ctrl #(
        .CLK_HZ      (50000000),
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK_50M   (clk),
        .RST       (rst),
        .PS2_CLK   (ps2_clk),
        .PS2_DATA  (ps2_data),
        .o_clk_oe  (clk_oe),
        .o_data_oe (data_oe),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ref_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) ones++;
        end
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Outcome of one command given the device's behaviour: line ACK or not,
    // then a list of responses (nfe resends followed by fin).
    function automatic void ref_model(input bit ack_fail, input int nfe, input logic [7:0] fin,
                                      output bit is_err, output logic [1:0] code, output int xfers);
        int retries = 0;
        logic [7:0] r;
        is_err = 1'b0;
        code   = 2'd0;
        xfers  = 1;
        if (ack_fail) begin
            is_err = 1'b1;
            code   = 2'd1;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            r = (i < nfe) ? 8'hFE : fin;
            if (r == 8'hFA) return;
            if (r == 8'hFE && retries < 2) begin
                retries++;
                xfers++;
            end else begin
                is_err = 1'b1;
                code   = (r == 8'hFE) ? 2'd2 : 2'd3;
                return;
            end
        end
    endfunction

    // Scoreboard monitor: every done/err pulse consumes one expected outcome.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.o_done && bus.o_err) check(1'b0, "done_and_err", 3, 1);
            if (bus.o_done || bus.o_err) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_outcome", int'({bus.o_done, bus.o_err}), 0);
                end else begin
                    e = sb.pop_front();
                    check(bus.o_err == e.is_err, "outcome_is_err", int'(bus.o_err), int'(e.is_err));
                    if (e.is_err) check(bus.o_err_code == e.code, "err_code", int'(bus.o_err_code), int'(e.code));
                    check(!clk_oe && !data_oe, "lines_released", int'({clk_oe, data_oe}), 0);
                end
            end
        end
    end

    // Inhibit episode monitor: clock held low exactly INH cycles, data asserted only in the last.
    always @(negedge clk) begin
        if (rst) begin
            inh_run   <= 0;
            inh_first <= 0;
        end else if (clk_oe) begin
            inh_run <= inh_run + 1;
            if (data_oe && inh_first == 0) inh_first <= inh_run + 1;
        end else if (inh_run != 0) begin
            check(inh_run == INH, "inhibit_length", inh_run, INH);
            check(inh_first == INH, "inhibit_data_rise", inh_first, INH);
            inh_run   <= 0;
            inh_first <= 0;
            inh_seen  <= inh_seen + 1;
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        int n = 0;
        while (!bus.o_cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(n < 1000, "ready_wait", n, 0);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_data  = b;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_byte  = b;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    // Device side of one host-to-device frame; stop_after>0 ends clocking after that fall.
    task automatic dev_xfer(input bit ack_low, input int stop_after, input int stray_at,
                            output logic [7:0] got, output logic par, output logic stop, output bit ok);
        int n = 0;
        logic [10:0] bits = 11'd0;
        ok = 1'b0; got = 8'd0; par = 1'b0; stop = 1'b0;
        while (!clk_oe && n < 3000) begin @(negedge clk); n++; end
        check(n < 3000, "wait_inhibit_start", n, 0);
        if (n >= 3000) return;
        n = 0;
        while (clk_oe && n < INH + 100) begin @(negedge clk); n++; end
        check(n < INH + 100, "wait_inhibit_end", n, 0);
        if (n >= INH + 100) return;
        check(ps2_data == 1'b0, "start_bit", int'(ps2_data), 0);
        check(bus.o_rx_inhibit == 1'b1, "rx_inhibit_tx", int'(bus.o_rx_inhibit), 1);
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack_low) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            if (k == stray_at) begin
                rx_pulse(RESP_ACK);
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            if (k <= 10) bits[k] = ps2_data;
            dev_clk_low = 1'b0;
            if (k == stop_after) begin
                ok = 1'b1;
                return;
            end
            repeat (H) @(negedge clk);
            if (k == 11) dev_data_low = 1'b0;
        end
        got  = bits[8:1];
        par  = bits[9];
        stop = bits[10];
        ok   = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check(sb.size() == 0, "drain_outcome", sb.size(), 0);
    endtask

    task automatic run_txn(input logic [7:0] b, input bit ack_fail, input int nfe, input logic [7:0] fin);
        exp_t e;
        int xfers, base;
        logic [7:0] got;
        logic par, stop;
        bit ok;
        ref_model(ack_fail, nfe, fin, e.is_err, e.code, xfers);
        base = inh_seen;
        sb.push_back(e);
        send_cmd(b);
        for (int x = 0; x < xfers; x++) begin
            dev_xfer(!ack_fail, 0, 0, got, par, stop, ok);
            if (!ok) break;
            check(got == b, "tx_byte", int'(got), int'(b));
            check(par == ref_parity(b), "tx_parity", int'(par), int'(ref_parity(b)));
            check(stop == 1'b1, "tx_stop", int'(stop), 1);
            if (!ack_fail) begin
                repeat (20) @(negedge clk);
                check(bus.o_rx_inhibit == 1'b0, "rx_inhibit_resp", int'(bus.o_rx_inhibit), 0);
                rx_pulse((x < nfe) ? RESP_RESEND : fin);
            end
        end
        drain();
        check(inh_seen - base == xfers, "transmissions", inh_seen - base, xfers);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: actual %0d checks, required completion", n_checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t e;
        int n, base;
        bit saw_oe;
        logic [7:0] got, fin;
        logic par, stop;
        bit ok;

        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_data  = 8'h00;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_byte   = 8'h00;
        repeat (3) @(negedge clk);
        check(!bus.o_cmd_ready && !clk_oe && !data_oe && !bus.o_done && !bus.o_err &&
              bus.o_err_code == 2'd0 && !bus.o_rx_inhibit, "reset_state",
              int'({bus.o_cmd_ready, clk_oe, data_oe, bus.o_done, bus.o_err, bus.o_err_code, bus.o_rx_inhibit}), 0);
        rst = 1'b0;
        @(negedge clk);
        check(bus.o_cmd_ready == 1'b1, "ready_after_reset", int'(bus.o_cmd_ready), 1);

        run_txn(8'hED, 1'b0, 0, RESP_ACK);
        run_txn(8'h00, 1'b0, 0, RESP_ACK);
        run_txn(8'hA5, 1'b0, 3, RESP_ACK);
        run_txn(8'h3C, 1'b1, 0, RESP_ACK);
        run_txn(8'h81, 1'b0, 1, 8'hAA);

        // Device stops clocking after fall 5: watchdog error expected.
        e.is_err = 1'b1;
        e.code   = 2'd0;
        sb.push_back(e);
        send_cmd(8'h5A);
        dev_xfer(1'b1, 5, 0, got, par, stop, ok);
        n = 0;
        while (!bus.o_err && n < TO + 200) begin @(negedge clk); n++; end
        check(H + n >= TO && H + n <= TO + 4, "timeout_latency", H + n, TO);
        check(!clk_oe && !data_oe, "timeout_lines", int'({clk_oe, data_oe}), 0);
        drain();

        // Reset mid-SHIFT: after fall 4 the host drives d3 of 0x00, i.e. data low.
        send_cmd(8'h00);
        dev_xfer(1'b1, 4, 0, got, par, stop, ok);
        check(data_oe == 1'b1, "shift_data_driven", int'(data_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        check(!clk_oe && !data_oe && !bus.o_cmd_ready, "reset_mid_shift",
              int'({clk_oe, data_oe, bus.o_cmd_ready}), 0);
        rst = 1'b0;
        @(negedge clk);
        check(bus.o_cmd_ready == 1'b1, "ready_after_release", int'(bus.o_cmd_ready), 1);

        // Command valid held through a transfer, data changed, stray rx strobe in SHIFT.
        e.is_err = 1'b0;
        e.code   = 2'd0;
        sb.push_back(e);
        base = inh_seen;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_data  = 8'h3C;
        @(negedge clk);
        bus.i_cmd_data  = 8'hC3;
        dev_xfer(1'b1, 0, 3, got, par, stop, ok);
        check(got == 8'h3C, "held_tx_byte", int'(got), 8'h3C);
        repeat (20) @(negedge clk);
        rx_pulse(RESP_ACK);
        n = 0;
        while (!bus.o_done && n < 10) begin @(negedge clk); n++; end
        check(bus.o_done == 1'b1, "held_done", int'(bus.o_done), 1);
        bus.i_cmd_valid = 1'b0;
        saw_oe = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (clk_oe) saw_oe = 1'b1;
        end
        check(!saw_oe, "no_second_accept", int'(saw_oe), 0);
        check(inh_seen - base == 1, "held_transmissions", inh_seen - base, 1);
        drain();

        for (int t = 0; t < 12; t++) begin
            fin = RESP_ACK;
            if ($urandom_range(0, 2) == 0) begin
                fin = 8'($urandom_range(0, 255));
                while (fin == RESP_ACK || fin == RESP_RESEND) fin = 8'($urandom_range(0, 255));
            end
            run_txn(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 3)), fin);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
